downscale_ctrl: RTL

//  Sequencer for bilinear_interp in the downscaling path. Walks every destination pixel
//  in raster order and derives Q8.8 source coordinates/weights. Fetches the 4 neighbour

---
 rtl/downscale_if.sv | 35 +++
 rtl/downscale_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/downscale_if.sv
// Bus bundle between downscale_ctrl and its environment: source frame reads,
// bilinear_interp launch/result handshake and destination writes.
//  master : the sequencer (drives strobes, addresses, neighbours, weights)
//  slave  : memories/interpolator side (drives read data and interp result)
interface downscale_if #(
  parameter int ADDR_W = 20
);
  logic              o_rd_en;
  logic [ADDR_W-1:0] o_rd_addr;
  logic [7:0]        i_rd_data;
  logic              o_interp_start;
  logic [7:0]        o_p1;
  logic [7:0]        o_p2;
  logic [7:0]        o_p3;
  logic [7:0]        o_p4;
  logic [15:0]       o_wx;
  logic [15:0]       o_wy;
  logic              i_interp_valid;
  logic [7:0]        i_interp_pixel;
  logic              o_wr_en;
  logic [ADDR_W-1:0] o_wr_addr;
  logic [7:0]        o_wr_data;

  modport master (
    output o_rd_en, o_rd_addr, o_interp_start, o_p1, o_p2, o_p3, o_p4,
           o_wx, o_wy, o_wr_en, o_wr_addr, o_wr_data,
    input  i_rd_data, i_interp_valid, i_interp_pixel
  );

  modport slave (
    input  o_rd_en, o_rd_addr, o_interp_start, o_p1, o_p2, o_p3, o_p4,
           o_wx, o_wy, o_wr_en, o_wr_addr, o_wr_data,
    output i_rd_data, i_interp_valid, i_interp_pixel
  );
endinterface

// File: rtl/downscale_ctrl.sv
// Downscale sequencer: walks destination pixels in raster order, derives Q8.8
// source coordinates, fetches the 4 neighbours, launches bilinear_interp and
// writes its result to destination memory. One pixel in flight at a time.
//  clk, rst_n          : clock, async active-low reset
//  i_start             : frame start pulse (ignored unless idle)
//  i_src_w/h, i_dst_w/h: frame dimensions, latched at start
//  i_scale_x/y         : Q8.8 source step per destination pixel
//  i_dst_base          : destination base address
//  o_busy, o_done      : frame in progress / 1-cycle completion pulse
//  bus                 : read, interpolator and write signals (downscale_if)
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | waiting for i_start; latches config
// S_FETCH  | 4 read cycles (p1..p4) plus 1 cycle to capture p4
// S_LAUNCH | 1-cycle o_interp_start, neighbours/weights already stable
// S_WAIT   | wait for i_interp_valid, latch pixel
// S_WRITE  | 1-cycle destination write, then advance or finish
// S_FIN    | 1-cycle o_done
module downscale_ctrl #(
  parameter int DIM_W  = 10,
  parameter int ADDR_W = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [DIM_W-1:0]  i_src_w,
  input  logic [DIM_W-1:0]  i_src_h,
  input  logic [DIM_W-1:0]  i_dst_w,
  input  logic [DIM_W-1:0]  i_dst_h,
  input  logic [15:0]       i_scale_x,
  input  logic [15:0]       i_scale_y,
  input  logic [ADDR_W-1:0] i_dst_base,
  output logic              o_busy,
  output logic              o_done,
  downscale_if.master       bus
);
  localparam int ACC_W = DIM_W + 8;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LAUNCH, S_WAIT, S_WRITE, S_FIN
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        fetch_cnt_q, fetch_cnt_d;
  logic [DIM_W-1:0]  src_w_q, src_w_d, src_h_q, src_h_d;
  logic [DIM_W-1:0]  dst_w_q, dst_w_d, dst_h_q, dst_h_d;
  logic [15:0]       scale_x_q, scale_x_d, scale_y_q, scale_y_d;
  logic [ADDR_W-1:0] dst_base_q, dst_base_d;
  logic [ACC_W-1:0]  ax_q, ax_d, ay_q, ay_d;
  logic [DIM_W-1:0]  dx_q, dx_d, dy_q, dy_d;
  logic [ADDR_W-1:0] wr_ofs_q, wr_ofs_d;
  logic [7:0]        p1_q, p1_d, p2_q, p2_d, p3_q, p3_d, p4_q, p4_d;
  logic [7:0]        pix_q, pix_d;

  // Neighbour coordinates, clamped into the source frame.
  logic [DIM_W-1:0]  src_w_m1, src_h_m1, x_int, y_int, x0, x1, y0, y1;
  logic [ADDR_W-1:0] row0, row1, rd_addr;

  assign src_w_m1 = src_w_q - DIM_W'(1);
  assign src_h_m1 = src_h_q - DIM_W'(1);
  assign x_int    = ax_q[ACC_W-1:8];
  assign y_int    = ay_q[ACC_W-1:8];
  assign x0       = (x_int > src_w_m1) ? src_w_m1 : x_int;
  assign y0       = (y_int > src_h_m1) ? src_h_m1 : y_int;
  assign x1       = (x0 < src_w_m1) ? x0 + DIM_W'(1) : x0;
  assign y1       = (y0 < src_h_m1) ? y0 + DIM_W'(1) : y0;
  assign row0     = ADDR_W'(y0) * ADDR_W'(src_w_q);
  assign row1     = ADDR_W'(y1) * ADDR_W'(src_w_q);

  // Fetch counter runs 4 -> 0; read order p1,p2,p3,p4.
  always_comb begin
    rd_addr = '0;
    case (fetch_cnt_q)
      3'd4:    rd_addr = row0 + ADDR_W'(x0);
      3'd3:    rd_addr = row0 + ADDR_W'(x1);
      3'd2:    rd_addr = row1 + ADDR_W'(x0);
      3'd1:    rd_addr = row1 + ADDR_W'(x1);
      default: rd_addr = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    fetch_cnt_d = fetch_cnt_q;
    src_w_d     = src_w_q;
    src_h_d     = src_h_q;
    dst_w_d     = dst_w_q;
    dst_h_d     = dst_h_q;
    scale_x_d   = scale_x_q;
    scale_y_d   = scale_y_q;
    dst_base_d  = dst_base_q;
    ax_d        = ax_q;
    ay_d        = ay_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    wr_ofs_d    = wr_ofs_q;
    p1_d        = p1_q;
    p2_d        = p2_q;
    p3_d        = p3_q;
    p4_d        = p4_q;
    pix_d       = pix_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          src_w_d     = i_src_w;
          src_h_d     = i_src_h;
          dst_w_d     = i_dst_w;
          dst_h_d     = i_dst_h;
          scale_x_d   = i_scale_x;
          scale_y_d   = i_scale_y;
          dst_base_d  = i_dst_base;
          ax_d        = '0;
          ay_d        = '0;
          dx_d        = '0;
          dy_d        = '0;
          wr_ofs_d    = '0;
          fetch_cnt_d = 3'd4;
          state_d     = (i_dst_w == '0 || i_dst_h == '0) ? S_FIN : S_FETCH;
        end
      end
      S_FETCH: begin
        // Read data lags the strobe by one cycle.
        case (fetch_cnt_q)
          3'd3:    p1_d = bus.i_rd_data;
          3'd2:    p2_d = bus.i_rd_data;
          3'd1:    p3_d = bus.i_rd_data;
          3'd0:    p4_d = bus.i_rd_data;
          default: ;
        endcase
        if (fetch_cnt_q == 3'd0) state_d = S_LAUNCH;
        else                     fetch_cnt_d = fetch_cnt_q - 3'd1;
      end
      S_LAUNCH: state_d = S_WAIT;
      S_WAIT: begin
        if (bus.i_interp_valid) begin
          pix_d   = bus.i_interp_pixel;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (dx_q == dst_w_q - DIM_W'(1)) begin
          if (dy_q == dst_h_q - DIM_W'(1)) begin
            state_d = S_FIN;
          end else begin
            dx_d  = '0;
            ax_d  = '0;
            dy_d  = dy_q + DIM_W'(1);
            ay_d  = ay_q + ACC_W'(scale_y_q);
          end
        end else begin
          dx_d = dx_q + DIM_W'(1);
          ax_d = ax_q + ACC_W'(scale_x_q);
        end
        if (state_d != S_FIN) begin
          wr_ofs_d    = wr_ofs_q + ADDR_W'(1);
          fetch_cnt_d = 3'd4;
          state_d     = S_FETCH;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      fetch_cnt_q <= '0;
      src_w_q     <= '0;
      src_h_q     <= '0;
      dst_w_q     <= '0;
      dst_h_q     <= '0;
      scale_x_q   <= '0;
      scale_y_q   <= '0;
      dst_base_q  <= '0;
      ax_q        <= '0;
      ay_q        <= '0;
      dx_q        <= '0;
      dy_q        <= '0;
      wr_ofs_q    <= '0;
      p1_q        <= '0;
      p2_q        <= '0;
      p3_q        <= '0;
      p4_q        <= '0;
      pix_q       <= '0;
    end else begin
      state_q     <= state_d;
      fetch_cnt_q <= fetch_cnt_d;
      src_w_q     <= src_w_d;
      src_h_q     <= src_h_d;
      dst_w_q     <= dst_w_d;
      dst_h_q     <= dst_h_d;
      scale_x_q   <= scale_x_d;
      scale_y_q   <= scale_y_d;
      dst_base_q  <= dst_base_d;
      ax_q        <= ax_d;
      ay_q        <= ay_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      wr_ofs_q    <= wr_ofs_d;
      p1_q        <= p1_d;
      p2_q        <= p2_d;
      p3_q        <= p3_d;
      p4_q        <= p4_d;
      pix_q       <= pix_d;
    end
  end

  assign bus.o_rd_en        = (state_q == S_FETCH) && (fetch_cnt_q != 3'd0);
  assign bus.o_rd_addr      = bus.o_rd_en ? rd_addr : '0;
  assign bus.o_interp_start = (state_q == S_LAUNCH);
  assign bus.o_p1           = p1_q;
  assign bus.o_p2           = p2_q;
  assign bus.o_p3           = p3_q;
  assign bus.o_p4           = p4_q;
  assign bus.o_wx           = {8'h00, ax_q[7:0]};
  assign bus.o_wy           = {8'h00, ay_q[7:0]};
  assign bus.o_wr_en        = (state_q == S_WRITE);
  assign bus.o_wr_addr      = bus.o_wr_en ? dst_base_q + wr_ofs_q : '0;
  assign bus.o_wr_data      = bus.o_wr_en ? pix_q : '0;
  assign o_busy             = (state_q == S_FETCH) || (state_q == S_LAUNCH) ||
                              (state_q == S_WAIT)  || (state_q == S_WRITE);
  assign o_done             = (state_q == S_FIN);
endmodule
